// File: rtl/ysyx_25030085_lsu_if.sv
// Bus interfaces of the load/store unit.
//
// ysyx_25030085_lsu_core_if : execute stage <-> LSU.
//   Request:  req_valid/req_ready handshake carrying req_wen, req_memop,
//             req_addr and req_wdata.
//   Response: resp_valid/resp_ready handshake carrying resp_rdata and
//             resp_err.
//   modport master = core side, modport slave = LSU side.
//
// ysyx_25030085_lsu_mem_if : LSU <-> data memory.
//   Request:  mem_valid/mem_ready handshake carrying mem_wen, mem_addr,
//             mem_wstrb and mem_wdata.
//   Response: mem_rvalid strobe with mem_rdata. This is read data for a
//             load and a write acknowledge for a store.
//   modport master = LSU side, modport slave = memory side.

interface ysyx_25030085_lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_memop, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_memop, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface ysyx_25030085_lsu_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit.
//
// The LSU takes one load or store request at a time from the execute
// stage. It turns the request into a single word-aligned data-memory
// transaction with byte strobes and lane-replicated write data. When the
// memory responds, the LSU hands back either a lane-extracted,
// sign- or zero-extended load result or an error.
//
// Errors are raised for:
//   - illegal memop encodings,
//   - unsigned stores,
//   - misaligned halfword or word accesses,
//   - a memory that does not respond within TIMEOUT cycles.
// A request that fails the legality check never reaches the memory.
//
// Ports:
//   clk   : clock; all state changes on its rising edge.
//   rst_n : asynchronous active-low reset.
//   core  : request/response handshakes with the execute stage (slave).
//   mem   : request handshake and response strobe with the data memory
//           (master).
//
// Parameter:
//   TIMEOUT : cycles allowed from request issue to memory response.
//             Legal range is 2..65535.

module ysyx_25030085_lsu #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic                             clk,
  input logic                             rst_n,
  ysyx_25030085_lsu_core_if.slave         core,
  ysyx_25030085_lsu_mem_if.master         mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsuState;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  lsuState     stateQ, stateD;

  // Request registers, captured at accept time. They drive the memory
  // port, so the port stays stable for the whole REQ phase.
  logic        wenQ;
  logic [2:0]  memopQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;

  logic [15:0] cntQ;
  logic [31:0] rdataQ;
  logic        errQ;

  // Control signals from the next-state logic.
  logic        latchReq;
  logic        clrCnt;
  logic        incCnt;
  logic        setResp;
  logic        respErrD;
  logic [31:0] respDataD;

  logic [1:0]  lane;
  logic [3:0]  wstrb;
  logic [31:0] wdataRep;
  logic [31:0] loadShift;
  logic [31:0] loadData;
  logic        reqIllegal;
  logic        timedOut;

  // Legality check on the live request, evaluated while in IDLE.
  function automatic logic isIllegal(input logic       wen,
                                     input logic [2:0] memop,
                                     input logic [1:0] addrLow);
    logic bad;
    case (memop)
      3'b000:  bad = 1'b0;                     // b
      3'b001:  bad = addrLow[0];               // h
      3'b010:  bad = (addrLow != 2'b00);       // w
      3'b100:  bad = wen;                      // bu: load only
      3'b101:  bad = wen | addrLow[0];         // hu: load only
      default: bad = 1'b1;                     // 011, 110, 111
    endcase
    return bad;
  endfunction

  assign reqIllegal = isIllegal(core.req_wen, core.req_memop, core.req_addr[1:0]);
  assign lane       = addrQ[1:0];

  // The counter can sit one past TIMEOUT_LAST. That happens when the
  // mem_ready handshake lands on the last allowed REQ cycle, so the
  // comparison uses >= rather than ==.
  assign timedOut = (cntQ >= TIMEOUT_LAST);

  // Store strobes and data replication.
  // Strobes are zero for loads, so the memory never sees a write strobe
  // on a read.
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the case statements can infer a latch.
    wstrb    = 4'b0000;
    wdataRep = wdataQ;
    case (memopQ[1:0])
      2'b00: begin
        wstrb    = 4'b0001 << lane;
        wdataRep = {4{wdataQ[7:0]}};
      end
      2'b01: begin
        wstrb    = 4'b0011 << lane;
        wdataRep = {2{wdataQ[15:0]}};
      end
      2'b10: begin
        wstrb    = 4'b1111;
      end
      default: begin
        wstrb    = 4'b0000;
      end
    endcase
    if (!wenQ) begin
      wstrb = 4'b0000;
    end
  end

  // Load lane extraction and extension.
  assign loadShift = mem.mem_rdata >> {lane, 3'b000};

  always_comb begin
    loadData = mem.mem_rdata;
    case (memopQ)
      3'b000:  loadData = {{24{loadShift[7]}}, loadShift[7:0]};
      3'b100:  loadData = {24'b0, loadShift[7:0]};
      3'b001:  loadData = {{16{loadShift[15]}}, loadShift[15:0]};
      3'b101:  loadData = {16'b0, loadShift[15:0]};
      default: loadData = mem.mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of block ordering.
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next state, plus the control strobes for the datapath registers.
  always_comb begin
    stateD    = stateQ;
    latchReq  = 1'b0;
    clrCnt    = 1'b0;
    incCnt    = 1'b0;
    setResp   = 1'b0;
    respErrD  = 1'b0;
    respDataD = 32'h0;
    case (stateQ)
      IDLE: begin
        if (core.req_valid) begin
          latchReq = 1'b1;
          if (reqIllegal) begin
            stateD   = RESP;
            setResp  = 1'b1;
            respErrD = 1'b1;
          end else begin
            stateD   = REQ;
            clrCnt   = 1'b1;
          end
        end
      end
      REQ: begin
        incCnt = 1'b1;
        // A mem_rvalid arriving together with mem_ready is ignored here.
        // The memory must present the response again in WAIT.
        if (mem.mem_ready) begin
          stateD = WAIT;
        end else if (timedOut) begin
          stateD   = RESP;
          setResp  = 1'b1;
          respErrD = 1'b1;
        end
      end
      WAIT: begin
        incCnt = 1'b1;
        if (mem.mem_rvalid) begin
          stateD    = RESP;
          setResp   = 1'b1;
          respDataD = wenQ ? 32'h0 : loadData;
        end else if (timedOut) begin
          stateD   = RESP;
          setResp  = 1'b1;
          respErrD = 1'b1;
        end
      end
      RESP: begin
        if (core.resp_ready) begin
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // Datapath registers: request latch, timeout counter, response holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wenQ   <= 1'b0;
      memopQ <= 3'b000;
      addrQ  <= 32'h0;
      wdataQ <= 32'h0;
      cntQ   <= 16'h0;
      rdataQ <= 32'h0;
      errQ   <= 1'b0;
    end else begin
      if (latchReq) begin
        wenQ   <= core.req_wen;
        memopQ <= core.req_memop;
        addrQ  <= core.req_addr;
        wdataQ <= core.req_wdata;
      end
      // The counter is frozen in RESP and IDLE. It is only cleared when a
      // legal request is accepted.
      if (clrCnt) begin
        cntQ <= 16'h0;
      end else if (incCnt) begin
        cntQ <= cntQ + 16'h1;
      end
      if (setResp) begin
        rdataQ <= respDataD;
        errQ   <= respErrD;
      end
    end
  end

  // Outputs. req_ready is qualified with rst_n so it reads low while the
  // unit is held in reset.
  assign core.req_ready  = (stateQ == IDLE) && rst_n;
  assign core.resp_valid = (stateQ == RESP);
  assign core.resp_rdata = rdataQ;
  assign core.resp_err   = errQ;

  assign mem.mem_valid   = (stateQ == REQ);
  assign mem.mem_wen     = wenQ;
  assign mem.mem_addr    = {addrQ[31:2], 2'b00};
  assign mem.mem_wstrb   = wstrb;
  assign mem.mem_wdata   = wdataRep;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Testbench for ysyx_25030085_lsu.
//
// Instances:
//   dutA : default TIMEOUT, used for the functional tests.
//   dutB : TIMEOUT=8, used for the timeout test.
//
// Expected responses and expected memory requests are pushed to queues
// when the stimulus is driven. They are popped and compared when the DUT
// presents them. All inputs are driven, and all outputs sampled, on the
// falling clock edge.

module tb_ysyx_25030085_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_25030085_lsu_core_if coreA ();
  ysyx_25030085_lsu_mem_if  memA ();
  ysyx_25030085_lsu_core_if coreB ();
  ysyx_25030085_lsu_mem_if  memB ();

  ysyx_25030085_lsu dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (coreA.slave),
    .mem   (memA.master)
  );

  ysyx_25030085_lsu #(.TIMEOUT(8)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (coreB.slave),
    .mem   (memB.master)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } respExp;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } memExp;

  respExp respQ[$];
  memExp  memQ[$];

  int nAssert = 0;
  int nFail   = 0;
  int lat;
  respExp gotExp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkResetA(input string tag);
    chk({tag, " req_ready"},  coreA.req_ready, 32'd0);
    chk({tag, " resp_valid"}, coreA.resp_valid, 32'd0);
    chk({tag, " resp_rdata"}, coreA.resp_rdata, 32'd0);
    chk({tag, " resp_err"},   coreA.resp_err, 32'd0);
    chk({tag, " mem_valid"},  memA.mem_valid, 32'd0);
    chk({tag, " mem_wen"},    memA.mem_wen, 32'd0);
    chk({tag, " mem_addr"},   memA.mem_addr, 32'd0);
    chk({tag, " mem_wstrb"},  memA.mem_wstrb, 32'd0);
    chk({tag, " mem_wdata"},  memA.mem_wdata, 32'd0);
  endtask

  // Runs one request on dutA.
  //   readyDly  : cycles mem_ready stays low in REQ.
  //   rvalidDly : cycles mem_rvalid stays low in WAIT.
  //   respDly   : cycles resp_ready stays low in RESP.
  // When rvalidDly > 0, a bogus mem_rvalid is also presented together with
  // mem_ready. It must be ignored.
  task automatic runA(input logic        wen,
                      input logic [2:0]  memop,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [31:0] memWord,
                      input int          readyDly,
                      input int          rvalidDly,
                      input int          respDly,
                      input logic        expMem,
                      input logic [31:0] expAddr,
                      input logic [3:0]  expStrb,
                      input logic [31:0] expWdata,
                      input logic        expErr,
                      input logic [31:0] expData);
    memExp  em;
    respExp er;
    @(negedge clk);
    chk("req_ready before accept", coreA.req_ready, 32'd1);
    coreA.req_valid = 1'b1;
    coreA.req_wen   = wen;
    coreA.req_memop = memop;
    coreA.req_addr  = addr;
    coreA.req_wdata = wdata;
    respQ.push_back('{rdata: expData, err: expErr});
    if (expMem) begin
      memQ.push_back('{wen: wen, addr: expAddr, strb: expStrb, wdata: expWdata});
    end
    @(negedge clk);
    coreA.req_valid = 1'b0;
    if (expMem) begin
      em = memQ.pop_front();
      for (int i = 0; i <= readyDly; i++) begin
        chk("mem_valid in REQ", memA.mem_valid, 32'd1);
        chk("mem_wen",          memA.mem_wen, {31'd0, em.wen});
        chk("mem_addr",         memA.mem_addr, em.addr);
        chk("mem_wstrb",        memA.mem_wstrb, {28'd0, em.strb});
        if (em.wen) begin
          chk("mem_wdata", memA.mem_wdata, em.wdata);
        end
        chk("req_ready in REQ",  coreA.req_ready, 32'd0);
        chk("resp_valid in REQ", coreA.resp_valid, 32'd0);
        if (i == readyDly) begin
          memA.mem_ready = 1'b1;
          if (rvalidDly > 0) begin
            memA.mem_rvalid = 1'b1;
            memA.mem_rdata  = ~memWord;
          end
        end
        @(negedge clk);
        memA.mem_ready  = 1'b0;
        memA.mem_rvalid = 1'b0;
      end
      for (int i = 0; i <= rvalidDly; i++) begin
        chk("mem_valid in WAIT",  memA.mem_valid, 32'd0);
        chk("resp_valid in WAIT", coreA.resp_valid, 32'd0);
        chk("req_ready in WAIT",  coreA.req_ready, 32'd0);
        if (i == rvalidDly) begin
          memA.mem_rvalid = 1'b1;
          memA.mem_rdata  = memWord;
        end
        @(negedge clk);
        memA.mem_rvalid = 1'b0;
      end
    end else begin
      chk("no mem_valid for illegal", memA.mem_valid, 32'd0);
    end
    er = respQ.pop_front();
    for (int i = 0; i <= respDly; i++) begin
      chk("resp_valid",        coreA.resp_valid, 32'd1);
      chk("resp_rdata",        coreA.resp_rdata, er.rdata);
      chk("resp_err",          coreA.resp_err, {31'd0, er.err});
      chk("req_ready in RESP", coreA.req_ready, 32'd0);
      if (i == respDly) begin
        coreA.resp_ready = 1'b1;
      end
      @(negedge clk);
      coreA.resp_ready = 1'b0;
    end
    chk("resp_valid after handshake", coreA.resp_valid, 32'd0);
    chk("req_ready after handshake",  coreA.req_ready, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    coreA.req_valid = 1'b0; coreA.req_wen = 1'b0; coreA.req_memop = 3'b000;
    coreA.req_addr = 32'h0; coreA.req_wdata = 32'h0; coreA.resp_ready = 1'b0;
    memA.mem_ready = 1'b0; memA.mem_rvalid = 1'b0; memA.mem_rdata = 32'h0;
    coreB.req_valid = 1'b0; coreB.req_wen = 1'b0; coreB.req_memop = 3'b000;
    coreB.req_addr = 32'h0; coreB.req_wdata = 32'h0; coreB.resp_ready = 1'b0;
    memB.mem_ready = 1'b0; memB.mem_rvalid = 1'b0; memB.mem_rdata = 32'h0;

    // Reset values.
    #1;
    chkResetA("reset");
    chk("reset B req_ready", coreB.req_ready, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_ready after reset", coreA.req_ready, 32'd1);

    // sb to lane 3, zero-wait memory.
    runA(1'b1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 32'h0, 0, 0, 0,
         1'b1, 32'h8000_0000, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0);

    // Loads against the word 0x80F17F02.
    runA(1'b0, 3'b000, 32'h101, 32'h0, 32'h80F1_7F02, 0, 0, 0,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h0000_007F);
    runA(1'b0, 3'b000, 32'h103, 32'h0, 32'h80F1_7F02, 0, 0, 0,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80);
    runA(1'b0, 3'b100, 32'h102, 32'h0, 32'h80F1_7F02, 0, 0, 0,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h0000_00F1);
    runA(1'b0, 3'b001, 32'h102, 32'h0, 32'h80F1_7F02, 0, 0, 0,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hFFFF_80F1);
    runA(1'b0, 3'b101, 32'h102, 32'h0, 32'h80F1_7F02, 0, 0, 0,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h0000_80F1);
    runA(1'b0, 3'b010, 32'h100, 32'h0, 32'h80F1_7F02, 0, 0, 0,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'h80F1_7F02);

    // Stores: sh to the upper half, then sw.
    runA(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 32'h0, 0, 0, 0,
         1'b1, 32'h100, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0);
    runA(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0, 0,
         1'b1, 32'h104, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);

    // Illegal requests: no memory access, error one cycle after accept.
    runA(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0,
         1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    runA(1'b1, 3'b001, 32'h101, 32'h5555_5555, 32'h0, 0, 0, 0,
         1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    runA(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0, 0,
         1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);
    runA(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 0,
         1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0);

    // Slow memory and a slow core, with a bogus early rvalid.
    runA(1'b0, 3'b001, 32'h102, 32'h0, 32'h80F1_7F02, 4, 3, 2,
         1'b1, 32'h100, 4'b0000, 32'h0, 1'b0, 32'hFFFF_80F1);

    // Timeout on dutB (TIMEOUT=8).
    // v=0: the memory never accepts. v=1: it accepts but never responds.
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      coreB.req_valid = 1'b1;
      coreB.req_wen   = 1'b0;
      coreB.req_memop = 3'b010;
      coreB.req_addr  = 32'h200;
      respQ.push_back('{rdata: 32'h0, err: 1'b1});
      @(negedge clk);
      coreB.req_valid = 1'b0;
      if (v == 1) begin
        memB.mem_ready = 1'b1;
      end
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        if (coreB.resp_valid) begin
          lat = c;
          break;
        end
        @(negedge clk);
        memB.mem_ready = 1'b0;
      end
      // REQ is entered one cycle after accept, and the timeout fires
      // 8 cycles later.
      chk("timeout latency", lat, 32'd9);
      gotExp = respQ.pop_front();
      chk("timeout resp_err",   coreB.resp_err, {31'd0, gotExp.err});
      chk("timeout resp_rdata", coreB.resp_rdata, gotExp.rdata);
      chk("timeout mem_valid",  memB.mem_valid, 32'd0);
      coreB.resp_ready = 1'b1;
      @(negedge clk);
      coreB.resp_ready = 1'b0;
      memB.mem_rvalid  = 1'b1;
      memB.mem_rdata   = 32'h1234_5678;
      @(negedge clk);
      memB.mem_rvalid  = 1'b0;
      for (int c = 0; c < 3; c++) begin
        chk("late rvalid ignored resp_valid", coreB.resp_valid, 32'd0);
        chk("late rvalid ignored mem_valid",  memB.mem_valid, 32'd0);
        chk("late rvalid ignored req_ready",  coreB.req_ready, 32'd1);
        @(negedge clk);
      end
    end

    // Reset during WAIT, then a late response, then a normal lw.
    @(negedge clk);
    coreA.req_valid = 1'b1;
    coreA.req_wen   = 1'b0;
    coreA.req_memop = 3'b010;
    coreA.req_addr  = 32'h104;
    @(negedge clk);
    coreA.req_valid = 1'b0;
    memA.mem_ready  = 1'b1;
    @(negedge clk);
    memA.mem_ready  = 1'b0;
    chk("pre-reset WAIT mem_valid",  memA.mem_valid, 32'd0);
    chk("pre-reset WAIT resp_valid", coreA.resp_valid, 32'd0);
    chk("pre-reset mem_addr",        memA.mem_addr, 32'h104);
    rst_n = 1'b0;
    #1;
    chkResetA("mid-reset");
    memA.mem_rvalid = 1'b1;
    memA.mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    memA.mem_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("post-reset resp_valid", coreA.resp_valid, 32'd0);
      chk("post-reset req_ready",  coreA.req_ready, 32'd1);
      @(negedge clk);
    end
    runA(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BAD_F00D, 0, 0, 0,
         1'b1, 32'h104, 4'b0000, 32'h0, 1'b0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_lsu.md
# ysyx_25030085_lsu

- Load/store unit that issues data-memory transactions on behalf of the core.
- Sits between the execute stage and the data memory:
  - Accepts one load or store request at a time on a valid/ready port.
  - Converts it into a word-aligned memory transaction with byte strobes and lane-replicated write data.
  - Waits for the memory's response.
  - Returns a lane-extracted, sign- or zero-extended load result, or an error, to the core.

## Interface
Parameters:
- TIMEOUT, default 256: cycles allowed from request issue to memory response; legal range 2..65535.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_memop  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address (rs1+imm)
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal op, or timeout
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_wen  out  1  write request
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte enables; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  32  read word

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch wen, memop, addr, wdata and classify the request.
    - Legal request -> REQ; clear the timeout counter.
    - Illegal request -> RESP with resp_err=1.
  - REQ: mem_valid=1. Outputs come from the latched registers and are stable until mem_ready. On mem_ready -> WAIT.
  - WAIT: sample mem_rvalid. When seen, latch the result -> RESP.
  - RESP: resp_valid=1 with resp_rdata and resp_err held stable. On resp_ready -> IDLE.
- Illegal requests:
  - memop 011, 110, 111.
  - memop 100 or 101 with wen=1.
  - h/hu with addr[0]=1.
  - w with addr[1:0]≠00.
  - No memory transaction is issued for any of these.
- Store lanes (lane = addr[1:0]):
  - sb: wstrb = 0001<<lane; wdata = {4{wdata[7:0]}}.
  - sh: wstrb = 0011<<lane; wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 1111; wdata unchanged.
- Load extraction: s = mem_rdata >> (8*lane).
  - lb: {{24{s[7]}},s[7:0]}
  - lbu: {24'b0,s[7:0]}
  - lh: {{16{s[15]}},s[15:0]}
  - lhu: {16'b0,s[15:0]}
  - lw: mem_rdata
- Timeout:
  - The 16-bit counter increments each cycle in REQ and WAIT.
  - When it reaches TIMEOUT-1 without completion: go to RESP with resp_err=1 and resp_rdata=0, and drop mem_valid.
- mem_rvalid outside WAIT is ignored. The memory must not respond before the mem_ready handshake or after TIMEOUT.

## Timing
- Reset values: state IDLE, req_ready=0 while rst_n low and 1 after, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_wen=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, counter=0.
- Legal request, zero-wait memory:
  - Accept at cycle 0.
  - mem_valid high in cycle 1; mem_ready in cycle 1.
  - WAIT in cycle 2; mem_rvalid in cycle 2.
  - resp_valid in cycle 3.
- Illegal request: accept at cycle 0, resp_valid with resp_err=1 in cycle 1.
- req_ready is combinational (state==IDLE && rst_n). Back-to-back requests therefore have at least one IDLE cycle between resp handshake and next accept.
- mem_ready and mem_rvalid high in the same REQ cycle: only mem_ready is honoured; mem_rvalid must be reasserted in WAIT.
- Reset mid-transaction: all outputs drop asynchronously to reset values and the in-flight access is abandoned. Any memory response arriving later in IDLE is discarded.
- resp_ready held low: RESP is held indefinitely with outputs stable. The timeout counter is frozen in RESP.

## Test plan
- sb req_addr=0x80000003, req_wdata=0x123456AB, mem_ready and rvalid immediate -> mem_addr=0x80000000, mem_wstrb=1000, mem_wdata=0xABABABAB, resp_err=0, resp_rdata=0, resp_valid at cycle 3.
- lb/lbu/lh/lhu/lw at addr 0x100..0x103 with mem_rdata=0x80F17F02 -> lb@+1 returns 0x0000007F; lb@+3 returns 0xFFFFFF80; lbu@+2 returns 0x000000F1; lh@+2 returns 0xFFFF80F1; lhu@+2 returns 0x000080F1; lw@+0 returns 0x80F17F02.
- lw at 0x102; sh at 0x101; memop 110 -> no mem_valid pulse, resp_valid at cycle 1 with resp_err=1 and resp_rdata=0.
- mem_ready delayed 4 cycles, then mem_rvalid delayed 3 cycles, resp_ready delayed 2 cycles -> mem_* outputs stable throughout REQ; resp outputs stable until handshake; req_ready low until return to IDLE.
- TIMEOUT=8, memory never asserts mem_rvalid -> resp_err=1 exactly 8 cycles after entering REQ; a mem_rvalid injected afterwards in IDLE produces no response.
- Assert rst_n=0 during WAIT, release, then issue a legal lw -> outputs at reset values immediately; the new lw completes normally with correct data.
